// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller decoded from the kcpsm6 write bus.
// Outputs are registered one cycle after the state/counter condition; bus writes are never stalled.
module seg_scan_ctrl #(
   parameter logic [7:0] BASE_PORT = 8'h10,
   parameter int         PRESCALE  = 50000,
   parameter int         BLANK     = 500
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       interrupt_ack,
   output logic [3:0] code,
   output logic [3:0] an,
   output logic       dp_n,
   output logic       frame_irq
);
   localparam int            CW         = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [7:0]    PORT_LO    = BASE_PORT;
   localparam logic [7:0]    PORT_HI    = BASE_PORT + 8'd1;
   localparam logic [7:0]    PORT_CTRL  = BASE_PORT + 8'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [15:0]   shadow, active, active_n;
   logic [7:0]    ctrl;
   logic [3:0]    dp_mask;
   logic          pending;
   logic          wr_lo, wr_hi, wr_ctrl;
   logic          frame_end, do_copy;

   assign wr_lo   = write_strobe && (port_id == PORT_LO);
   assign wr_hi   = write_strobe && (port_id == PORT_HI);
   assign wr_ctrl = write_strobe && (port_id == PORT_CTRL);
   assign dp_mask = ctrl[7:4];

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      frame_end = 1'b0;
      if (!ctrl[0]) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_n = ST_BLANK;
               cnt_n   = '0;
               idx_n   = '0;
            end
            default: begin
               if (cnt == CNT_LAST) begin
                  state_n   = ST_BLANK;
                  cnt_n     = '0;
                  idx_n     = idx + 2'd1;
                  frame_end = (idx == 2'd3);
               end else begin
                  cnt_n = cnt + CW'(1);
                  if (state == ST_BLANK && cnt == BLANK_LAST)
                     state_n = ST_SHOW;
               end
            end
         endcase
      end
   end

   // Copy samples the shadow before any same-cycle write lands, so that write waits a frame.
   assign do_copy  = frame_end && pending;
   assign active_n = do_copy ? shadow : active;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shadow    <= '0;
         active    <= '0;
         ctrl      <= '0;
         pending   <= 1'b0;
         code      <= 4'h0;
         an        <= 4'hF;
         dp_n      <= 1'b1;
         frame_irq <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         active <= active_n;
         if (wr_lo)
            shadow[7:0] <= out_port;
         if (wr_hi)
            shadow[15:8] <= out_port;
         if (wr_ctrl)
            ctrl <= out_port;
         if (wr_lo || wr_hi)
            pending <= 1'b1;
         else if (do_copy)
            pending <= 1'b0;
         if (frame_end && ctrl[1])
            frame_irq <= 1'b1;
         else if (interrupt_ack)
            frame_irq <= 1'b0;
         code <= active_n[{idx_n, 2'b00} +: 4];
         an   <= (state_n == ST_SHOW) ? ~(4'b0001 << idx_n) : 4'hF;
         dp_n <= !((state_n == ST_SHOW) && dp_mask[idx_n]);
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, BLANK=2, BASE_PORT=8'h10.
module tb_seg_scan_ctrl;
   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       interrupt_ack = 1'b0;
   logic [3:0] code, an;
   logic       dp_n, frame_irq;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   seg_scan_ctrl #(.BASE_PORT(8'h10), .PRESCALE(8), .BLANK(2)) dut (
      .CLK(CLK), .rst(rst), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .code(code), .an(an), .dp_n(dp_n), .frame_irq(frame_irq)
   );

   // Each row: drive inputs for one cycle, idle for n-1 more, then check outputs.
   typedef struct {
      logic       rst, ws, ack;
      logic [7:0] port, dat;
      int         n;
      logic [3:0] an, code;
      logic       dp_n, irq;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic r, input logic w, input logic a,
                               input logic [7:0] p, input logic [7:0] d, input int n,
                               input logic [3:0] e_an, input logic [3:0] e_code,
                               input logic e_dp, input logic e_irq);
      vec_t v;
      v.rst = r; v.ws = w; v.ack = a; v.port = p; v.dat = d; v.n = n;
      v.an = e_an; v.code = e_code; v.dp_n = e_dp; v.irq = e_irq;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int blank_cnt, show_cnt, waited;

      //    rst ws ack port   data   n   an    code  dp irq
      // reset and idle
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 10, 4'hF, 4'h0, 1, 0);
      // basic scan: first frame shows zeros, second frame 1,2,3,4
      add(0, 1, 0, 8'h10, 8'h21,  1, 4'hF, 4'h0, 1, 0);
      add(0, 1, 0, 8'h11, 8'h43,  1, 4'hF, 4'h0, 1, 0);
      add(0, 1, 0, 8'h12, 8'h01,  1, 4'hF, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  2, 4'hE, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  6, 4'hF, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  2, 4'hD, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 21, 4'h7, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h1, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h1, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hE, 4'h1, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  5, 4'hE, 4'h1, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h2, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  2, 4'hD, 4'h2, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'hB, 4'h3, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'h7, 4'h4, 1, 0);
      // tear-free update during digit 1 show
      add(0, 0, 0, 8'h00, 8'h00, 16, 4'hD, 4'h2, 1, 0);
      add(0, 1, 0, 8'h10, 8'hAB,  1, 4'hD, 4'h2, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'hB, 4'h3, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'h7, 4'h4, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  5, 4'hF, 4'hB, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 10, 4'hD, 4'hA, 1, 0);
      // pending write, then a second write on the frame-end cycle
      add(0, 1, 0, 8'h11, 8'h65,  1, 4'hD, 4'hA, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 20, 4'h7, 4'h4, 1, 0);
      add(0, 1, 0, 8'h10, 8'h87,  1, 4'hF, 4'hB, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 10, 4'hD, 4'hA, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'hB, 4'h5, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'h7, 4'h6, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'hE, 4'h7, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  8, 4'hD, 4'h8, 1, 0);
      // interrupt handshake
      add(0, 1, 0, 8'h12, 8'h03,  1, 4'hD, 4'h8, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 20, 4'h7, 4'h6, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h7, 1, 1);
      add(0, 0, 0, 8'h00, 8'h00, 10, 4'hD, 4'h8, 1, 1);
      add(0, 0, 1, 8'h00, 8'h00,  1, 4'hD, 4'h8, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 20, 4'h7, 4'h6, 1, 0);
      add(0, 0, 1, 8'h00, 8'h00,  1, 4'hF, 4'h7, 1, 1);
      add(0, 0, 1, 8'h00, 8'h00,  1, 4'hF, 4'h7, 1, 0);
      // decimal point on digit 2, irq disabled, then disable mid-show
      add(0, 1, 0, 8'h12, 8'h41,  1, 4'hE, 4'h7, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 16, 4'hB, 4'h5, 0, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hB, 4'h5, 0, 0);
      add(0, 0, 0, 8'h00, 8'h00,  5, 4'hF, 4'h6, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  2, 4'h7, 4'h6, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00,  6, 4'hF, 4'h7, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 19, 4'hB, 4'h5, 0, 0);
      add(0, 1, 0, 8'h12, 8'h00,  1, 4'hB, 4'h5, 0, 0);
      add(0, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h7, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 40, 4'hF, 4'h7, 1, 0);
      // unmapped ports, re-enable, then reset mid-show of digit 2
      add(0, 1, 0, 8'h13, 8'h99,  4, 4'hF, 4'h7, 1, 0);
      add(0, 1, 0, 8'h0F, 8'h99,  4, 4'hF, 4'h7, 1, 0);
      add(0, 1, 0, 8'h12, 8'h03,  1, 4'hF, 4'h7, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 11, 4'hD, 4'h8, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 32, 4'hD, 4'h8, 1, 1);
      add(0, 0, 0, 8'h00, 8'h00,  9, 4'hB, 4'h5, 1, 1);
      add(1, 0, 0, 8'h00, 8'h00,  1, 4'hF, 4'h0, 1, 0);
      add(0, 0, 0, 8'h00, 8'h00, 20, 4'hF, 4'h0, 1, 0);

      repeat (3) tick();
      rst = 1'b0;

      foreach (vecs[i]) begin
         rst           = vecs[i].rst;
         write_strobe  = vecs[i].ws;
         port_id       = vecs[i].port;
         out_port      = vecs[i].dat;
         interrupt_ack = vecs[i].ack;
         tick();
         rst           = 1'b0;
         write_strobe  = 1'b0;
         interrupt_ack = 1'b0;
         repeat (vecs[i].n - 1) tick();
         chk("an", i, 32'(an), 32'(vecs[i].an));
         chk("code", i, 32'(code), 32'(vecs[i].code));
         chk("dp_n", i, 32'(dp_n), 32'(vecs[i].dp_n));
         chk("frame_irq", i, 32'(frame_irq), 32'(vecs[i].irq));
      end

      // Slot shape after a fresh enable: 2 blank cycles then 6 lit on digit 0.
      write_strobe = 1'b1;
      port_id      = 8'h12;
      out_port     = 8'h01;
      tick();
      write_strobe = 1'b0;
      chk("enable_an", 0, 32'(an), 32'hF);
      blank_cnt = 0;
      show_cnt  = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (an == 4'hF)
            blank_cnt++;
         else if (an == 4'hE)
            show_cnt++;
      end
      chk("slot_blank_cycles", 0, 32'(blank_cnt), 32'd2);
      chk("slot_show_cycles", 0, 32'(show_cnt), 32'd6);
      waited = 0;
      while (an != 4'hD && waited < 20) begin
         tick();
         waited++;
      end
      chk("digit1_lit_delay", 0, 32'(waited), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
